hex_scroll_ctrl: RTL and testbench

//  Sequencer for the six DE-series HEX displays: stores a message of up to DEPTH
//  hex digits and scrolls it right-to-left across HEX5..HEX0 at a fixed rate.

---
 rtl/hex_scroll_ctrl_if.sv | 23 ++
 rtl/hex_scroll_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_scroll_ctrl_if.sv
// Control/status bundle between user logic and the HEX scroll sequencer.
// The master side supplies digits and commands; the slave side reports progress.
interface hex_scroll_ctrl_if;
  logic       wr_valid;
  logic [3:0] wr_digit;
  logic       wr_ready;
  logic       clear;
  logic       start;
  logic       stop;
  logic       busy;
  logic [5:0] len;
  logic       wrapped;

  modport master (
    output wr_valid, wr_digit, clear, start, stop,
    input  wr_ready, busy, len, wrapped
  );

  modport slave (
    input  wr_valid, wr_digit, clear, start, stop,
    output wr_ready, busy, len, wrapped
  );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Stores up to DEPTH hex digits and scrolls them right-to-left across HEX5..HEX0,
// preceded by six blanks so the message enters from the right and fully exits.
module hex_scroll_ctrl #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  hex_scroll_ctrl_if.slave bus,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    S_IDLE,
    S_SCROLL
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [5:0]     r_len;
  logic [5:0]     r_pos;
  logic [TW-1:0]  r_tick;
  logic           r_wrapped;
  logic [3:0]     r_buf [DEPTH];
  logic [6:0]     r_hex [6];

  logic           w_wr_ready;
  logic           w_wr_fire;
  logic [5:0]     w_len_after;
  logic           w_run;
  logic           w_tick_end;
  logic [6:0]     w_stream_len;
  logic           w_last;
  logic [6:0]     w_idx [6];
  logic [6:0]     w_win [6];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_ready  = 1'b0;
    w_wr_fire   = 1'b0;
    w_len_after = r_len;
    unique case (r_state)
      S_IDLE: begin
        w_wr_ready = (r_len < 6'(DEPTH));
        // clear wins over a same-cycle write; start sees the post-write length
        w_wr_fire  = bus.wr_valid && w_wr_ready && !bus.clear;
        if (bus.clear) begin
          w_len_after = '0;
        end else if (w_wr_fire) begin
          w_len_after = r_len + 6'd1;
        end
        if (bus.start && (w_len_after != 6'd0)) begin
          w_state_nxt = S_SCROLL;
        end
      end
      S_SCROLL: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_run        = (r_state == S_SCROLL) && !bus.stop;
  assign w_tick_end   = (r_tick == TW'(TICK_DIV - 1));
  assign w_stream_len = {1'b0, r_len} + 7'd6;
  assign w_last       = ({1'b0, r_pos} == (w_stream_len - 7'd1));

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_len     <= '0;
      r_pos     <= '0;
      r_tick    <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_len     <= w_len_after;
      r_wrapped <= 1'b0;
      if (w_run) begin
        if (w_tick_end) begin
          r_tick <= '0;
          if (w_last) begin
            r_pos     <= '0;
            r_wrapped <= 1'b1;
          end else begin
            r_pos <= r_pos + 6'd1;
          end
        end else begin
          r_tick <= r_tick + TW'(1);
        end
      end else begin
        r_tick <= '0;
        r_pos  <= '0;
      end
    end
  end

  // NOTE: the message RAM is deliberately not reset; len alone defines which
  // entries are valid, and leaving it reset-free keeps it mappable to RAM.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset && w_wr_fire) begin
      r_buf[r_len[AW-1:0]] <= bus.wr_digit;
    end
  end

  // Window digit j (HEXj) shows stream entry pos+(5-j); one subtract folds it mod L
  // because pos < L and the offset never exceeds 5 < L.
  always_comb begin
    for (int j = 0; j < 6; j++) begin
      w_idx[j] = {1'b0, r_pos} + 7'(5 - j);
      if (w_idx[j] >= w_stream_len) begin
        w_idx[j] = w_idx[j] - w_stream_len;
      end
      if (w_idx[j] < 7'd6) begin
        w_win[j] = SEG_BLANK;
      end else begin
        w_win[j] = seg7(r_buf[AW'(w_idx[j] - 7'd6)]);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    for (int j = 0; j < 6; j++) begin
      if (Reset || (r_state != S_SCROLL)) begin
        r_hex[j] <= SEG_BLANK;
      end else begin
        r_hex[j] <= w_win[j];
      end
    end
  end

  assign bus.wr_ready = w_wr_ready;
  assign bus.busy     = (r_state == S_SCROLL);
  assign bus.len      = r_len;
  assign bus.wrapped  = r_wrapped;

  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl: a digit/position model predicts each HEX
// window, expectations are queued when stimulus is applied and popped at sample points.
module tb_hex_scroll_ctrl;

  localparam int DEPTH    = 16;
  localparam int TICK_DIV = 4;

  logic       clk;
  logic       rst;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] hex_now;

  hex_scroll_ctrl_if bus();

  hex_scroll_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5)
  );

  assign hex_now = {hex5, hex4, hex3, hex2, hex1, hex0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          passed;
  logic [3:0]  model_msg [DEPTH];
  int          model_len;
  int          model_pos;
  logic [41:0] exp_q [$];
  string       tag_q [$];

  localparam logic [41:0] ALL_BLANK = {42{1'b1}};

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // HEX5 shows stream[p], HEX0 shows stream[p+5]; stream = 6 blanks then the message.
  function automatic logic [41:0] win(input int p);
    logic [41:0] w;
    int len_s;
    int idx;
    w = ALL_BLANK;
    len_s = model_len + 6;
    for (int k = 0; k < 6; k++) begin
      idx = (p + k) % len_s;
      if (idx >= 6) w[(5 - k) * 7 +: 7] = seg(model_msg[idx - 6]);
    end
    return w;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_hex(input string tag, input logic [41:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_hex();
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL sb_underflow: observed=empty expected=entry");
    end else begin
      check(tag_q.pop_front(), {22'd0, hex_now}, {22'd0, exp_q.pop_front()});
    end
  endtask

  task automatic wr(input logic [3:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_digit = d;
    cyc();
    bus.wr_valid = 1'b0;
    if (model_len < DEPTH) begin
      model_msg[model_len] = d;
      model_len++;
    end
  endtask

  // Leaves the bench one cycle after SCROLL was entered.
  task automatic start_scroll();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    model_pos = 0;
    cyc();
  endtask

  // Each step: pos moves on the 4th edge of a tick period, HEX follows one edge later.
  task automatic scroll_steps(input int n);
    for (int s = 0; s < n; s++) begin
      model_pos = (model_pos + 1) % (model_len + 6);
      push_hex($sformatf("hex_pos%0d_len%0d", model_pos, model_len), win(model_pos));
      repeat (TICK_DIV - 1) cyc();
      check($sformatf("wrapped_pos%0d", model_pos), {63'd0, bus.wrapped},
            {63'd0, (model_pos == 0)});
      cyc();
      pop_hex();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    total = 0;
    passed = 0;
    model_len = 0;
    model_pos = 0;
    bus.wr_valid = 1'b0;
    bus.wr_digit = 4'h0;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    rst = 1'b1;
    repeat (2) cyc();

    check("rst_len", {58'd0, bus.len}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_wrapped", {63'd0, bus.wrapped}, 64'd0);
    check("rst_wr_ready", {63'd0, bus.wr_ready}, 64'd1);
    push_hex("rst_hex", ALL_BLANK);
    pop_hex();
    rst = 1'b0;

    wr(4'h1);
    wr(4'h2);
    wr(4'h3);
    check("len_after_3", {58'd0, bus.len}, 64'(model_len));
    check("wr_ready_3", {63'd0, bus.wr_ready}, 64'd1);
    push_hex("idle_hex", ALL_BLANK);
    pop_hex();

    start_scroll();
    check("busy_scroll", {63'd0, bus.busy}, 64'd1);
    scroll_steps(9);
    check("wrapped_pulse_end", {63'd0, bus.wrapped}, 64'd0);
    scroll_steps(2);

    bus.start = 1'b1;
    bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    cyc();
    check("stop_busy", {63'd0, bus.busy}, 64'd0);
    check("stop_len", {58'd0, bus.len}, 64'(model_len));
    push_hex("stop_hex", ALL_BLANK);
    pop_hex();

    start_scroll();
    scroll_steps(4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_len = 0;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_len", {58'd0, bus.len}, 64'd0);
    check("midrst_wrapped", {63'd0, bus.wrapped}, 64'd0);
    check("midrst_wr_ready", {63'd0, bus.wr_ready}, 64'd1);
    push_hex("midrst_hex", ALL_BLANK);
    pop_hex();

    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    check("start_empty_busy", {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < DEPTH; i++) wr(4'(i));
    check("full_len", {58'd0, bus.len}, 64'd16);
    check("full_wr_ready", {63'd0, bus.wr_ready}, 64'd0);
    wr(4'h7);
    check("overflow_len", {58'd0, bus.len}, 64'(model_len));

    bus.clear = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_digit = 4'h9;
    cyc();
    bus.clear = 1'b0;
    bus.wr_valid = 1'b0;
    model_len = 0;
    check("clear_len", {58'd0, bus.len}, 64'd0);
    check("clear_wr_ready", {63'd0, bus.wr_ready}, 64'd1);

    bus.start = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_digit = 4'hA;
    cyc();
    bus.start = 1'b0;
    bus.wr_valid = 1'b0;
    model_msg[0] = 4'hA;
    model_len = 1;
    model_pos = 0;
    cyc();
    check("startwr_busy", {63'd0, bus.busy}, 64'd1);
    check("startwr_len", {58'd0, bus.len}, 64'd1);
    scroll_steps(8);

    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    cyc();
    check("final_busy", {63'd0, bus.busy}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
